seq_detector: RTL and testbench

Serial pattern detector that consumes the registered bit stream produced by the upstream `d_ff` stage. Its `Din` input is wired to the flip-flop's `Q`. It recognises the overlapping 4-bit pattern 1011, oldest bit first. On each match it emits a one-cycle `Detect` pulse and advances a saturating match counter. It is the first control stage after the input-sampling flip-flop in the serial datapath.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/sat_counter.sv | 35 +++
 rtl/seq_detector.sv | 70 +++++++
 tb/tb_seq_detector.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the 1011 serial pattern detector: state encodings and pattern definition.
package seq_det_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_1    = 3'd1;
    localparam logic [STATE_W-1:0] S_10   = 3'd2;
    localparam logic [STATE_W-1:0] S_101  = 3'd3;
    localparam logic [STATE_W-1:0] S_1011 = 3'd4;

    localparam int unsigned PATTERN_LEN = 4;
    localparam logic [PATTERN_LEN-1:0] PATTERN = 4'b1011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Clear,
    input  logic         Inc,
    output logic [W-1:0] Q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (Clear) begin
            cnt_d = '0;
        end else if (Inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Overlapping 1011 detector on a registered serial stream; pulses Detect and counts matches.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               Din,
    input  logic               Clear,
    output logic               Detect,
    output logic [COUNT_W-1:0] Count,
    output logic [2:0]         State
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] next_state;
    logic               detect_q;
    logic               detect_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each state is the longest matched prefix; illegal encodings fall back to idle.
    always_comb begin
        next_state = S_IDLE;
        unique case (state_q)
            S_IDLE:  next_state = Din ? S_1    : S_IDLE;
            S_1:     next_state = Din ? S_1    : S_10;
            S_10:    next_state = Din ? S_101  : S_IDLE;
            S_101:   next_state = Din ? S_1011 : S_10;
            S_1011:  next_state = Din ? S_1    : S_10;
            default: next_state = S_IDLE;
        endcase
        state_d = Enable ? next_state : state_q;
    end

    always_comb begin
        detect_d = Enable && (next_state == S_1011);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            detect_q <= 1'b0;
        end else begin
            detect_q <= detect_d;
        end
    end

    sat_counter #(
        .W (COUNT_W)
    ) u_sat_counter (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Clear),
        .Inc   (detect_d),
        .Q     (Count)
    );

    assign Detect = detect_q;
    assign State  = state_q;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: default-width and 2-bit-counter instances share one stimulus stream.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       din_drv;
    logic       clr;
    logic       use_dff;
    logic       dff_d;
    logic       dff_q;
    logic       din;

    logic       det8;
    logic [7:0] cnt8;
    logic [2:0] st8;
    logic       det2;
    logic [1:0] cnt2;
    logic [2:0] st2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Upstream input-sampling flip-flop.
    always @(posedge clk) begin
        if (rst) dff_q <= 1'b0;
        else     dff_q <= dff_d;
    end

    assign din = use_dff ? dff_q : din_drv;

    seq_detector #(.COUNT_W(8)) dut8 (
        .Clock  (clk),
        .Reset  (rst),
        .Enable (en),
        .Din    (din),
        .Clear  (clr),
        .Detect (det8),
        .Count  (cnt8),
        .State  (st8)
    );

    seq_detector #(.COUNT_W(2)) dut2 (
        .Clock  (clk),
        .Reset  (rst),
        .Enable (en),
        .Din    (din),
        .Clear  (clr),
        .Detect (det2),
        .Count  (cnt2),
        .State  (st2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic d, input logic c, input logic r);
        @(negedge clk);
        en      = e;
        din_drv = d;
        clr     = c;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic d_seq [6];
        logic dv;
        d_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b0; din_drv = 1'b0; clr = 1'b0;
        use_dff = 1'b0; dff_d = 1'b0;

        // Reset values
        do_reset();
        chk("reset_detect", 32'(det8), 32'd0);
        chk("reset_count",  32'(cnt8), 32'd0);
        chk("reset_state",  32'(st8),  32'd0);
        chk("reset_count2", 32'(cnt2), 32'd0);

        // Basic 1011 match
        step(1, 1, 0, 0); chk("basic_st1", 32'(st8), 32'd1);
        step(1, 0, 0, 0); chk("basic_st2", 32'(st8), 32'd2);
        step(1, 1, 0, 0); chk("basic_st3", 32'(st8), 32'd3);
        chk("basic_nodet3", 32'(det8), 32'd0);
        step(1, 1, 0, 0);
        chk("basic_det",   32'(det8), 32'd1);
        chk("basic_count", 32'(cnt8), 32'd1);
        chk("basic_st4",   32'(st8),  32'd4);
        step(1, 0, 0, 0);
        chk("basic_pulse_end", 32'(det8), 32'd0);
        chk("basic_st_after",  32'(st8),  32'd2);
        chk("basic_count_hold", 32'(cnt8), 32'd1);

        // Overlap: 1011011 gives two pulses three cycles apart
        do_reset();
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        step(1, 1, 0, 0); chk("ovl_det1", 32'(det8), 32'd1);
        step(1, 0, 0, 0); chk("ovl_gap1", 32'(det8), 32'd0);
        step(1, 1, 0, 0); chk("ovl_gap2", 32'(det8), 32'd0);
        step(1, 1, 0, 0); chk("ovl_det2", 32'(det8), 32'd1);
        chk("ovl_count",  32'(cnt8), 32'd2);
        chk("ovl_count2", 32'(cnt2), 32'd2);

        // Enable gating: state holds at S_101 while Din toggles
        do_reset();
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'(i % 2), 0, 0);
            chk("gate_hold_state", 32'(st8), 32'd3);
            chk("gate_hold_det",   32'(det8), 32'd0);
        end
        step(1, 1, 0, 0);
        chk("gate_det",   32'(det8), 32'd1);
        chk("gate_count", 32'(cnt8), 32'd1);
        chk("gate_state", 32'(st8),  32'd4);
        step(0, 0, 0, 0);
        chk("gate_pulse_drop", 32'(det8), 32'd0);
        chk("gate_state_hold", 32'(st8),  32'd4);

        // Saturation: six back-to-back patterns
        do_reset();
        for (int p = 0; p < 6; p++) begin
            step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
            step(1, 1, 0, 0);
            chk("sat_det2",   32'(det2), 32'd1);
            chk("sat_count2", 32'(cnt2), (p < 3) ? 32'(p + 1) : 32'd3);
            chk("sat_count8", 32'(cnt8), 32'(p + 1));
        end

        // Clear coinciding with a match wins over the increment
        do_reset();
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        chk("clr_pre_count", 32'(cnt8), 32'd1);
        step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 1, 0);
        chk("clr_det",   32'(det8), 32'd1);
        chk("clr_count", 32'(cnt8), 32'd0);
        chk("clr_count2", 32'(cnt2), 32'd0);
        step(1, 0, 0, 0);
        chk("clr_count_after", 32'(cnt8), 32'd0);

        // Reset mid-pattern discards the partial match
        do_reset();
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        chk("midrst_state", 32'(st8), 32'd0);
        chk("midrst_det",   32'(det8), 32'd0);
        step(1, 1, 0, 0);
        chk("midrst_nodet", 32'(det8), 32'd0);
        chk("midrst_st1",   32'(st8),  32'd1);

        // Integration through the upstream flip-flop
        do_reset();
        use_dff = 1'b1;
        for (int k = 0; k < 7; k++) begin
            dv = (k < 6) ? d_seq[k] : 1'b0;
            dff_d = dv;
            step(1, 0, 0, 0);
            chk("integ_det", 32'(det8), (k == 5) ? 32'd1 : 32'd0);
        end
        chk("integ_count", 32'(cnt8), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
